// File: rtl/imem_responder_if.sv
// Fetch/response handshake and program-load write port shared by the core and the
// instruction-memory responder.
`timescale 1ns/1ps
interface imem_responder_if #(
  parameter int ADDR_W = 8
);
  logic              io_req_valid;
  logic              io_req_ready;
  logic [31:0]       io_req_addr;
  logic              io_resp_valid;
  logic              io_resp_ready;
  logic [31:0]       io_resp_data;
  logic              io_resp_err;
  logic              io_wr_en;
  logic [ADDR_W-1:0] io_wr_addr;
  logic [31:0]       io_wr_data;

  modport master (
    output io_req_valid, io_req_addr, io_resp_ready, io_wr_en, io_wr_addr, io_wr_data,
    input  io_req_ready, io_resp_valid, io_resp_data, io_resp_err
  );

  modport slave (
    input  io_req_valid, io_req_addr, io_resp_ready, io_wr_en, io_wr_addr, io_wr_data,
    output io_req_ready, io_resp_valid, io_resp_data, io_resp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch at a time, fixed LATENCY, response held until taken.
// Define IMEM_STATS_EN to build the saturating request/error counters.
`timescale 1ns/1ps
module imem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  imem_responder_if.slave     bus,
  output logic                io_busy,
  output logic [15:0]         io_stat_reqs,
  output logic [15:0]         io_stat_errs
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0]  LAT_M1   = 4'(LATENCY - 1);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;
  logic [ADDR_W-1:0] r_idx;
  logic              r_err;
  logic [31:0]       r_mem [0:(1<<ADDR_W)-1];
  logic [31:0]       r_resp_data;
  logic              r_resp_err;

  logic              w_req_ready;
  logic              w_accept;
  logic              w_load;
  logic [ADDR_W-1:0] w_acc_idx;
  logic              w_acc_err;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_rd_err;
  logic [31:0]       w_rd_word;

  assign w_acc_idx = bus.io_req_addr[ADDR_W+1:2];
  assign w_acc_err = (bus.io_req_addr[1:0] != 2'b00) ||
                     (bus.io_req_addr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});

  // WAIT reads the captured address; an accept with LATENCY=1 reads the live one.
  assign w_rd_idx  = (r_state == ST_WAIT) ? r_idx : w_acc_idx;
  assign w_rd_err  = (r_state == ST_WAIT) ? r_err : w_acc_err;
  assign w_rd_word = (bus.io_wr_en && (bus.io_wr_addr == w_rd_idx)) ? bus.io_wr_data
                                                                   : r_mem[w_rd_idx];

  // Next-state, counter and handshake decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_req_ready  = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: w_req_ready = 1'b1;
      ST_WAIT: w_req_ready = 1'b0;
      ST_RESP: w_req_ready = bus.io_resp_ready;
      default: w_req_ready = 1'b0;
    endcase
    w_accept = bus.io_req_valid && w_req_ready;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_next = ST_RESP;
            w_load       = 1'b1;
          end else begin
            w_state_next = ST_WAIT;
            w_cnt_next   = LAT_M1;
          end
        end else if ((r_state == ST_RESP) && bus.io_resp_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = r_state;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_next = ST_RESP;
          w_cnt_next   = 4'd0;
          w_load       = 1'b1;
        end else begin
          w_cnt_next   = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Program image; deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (bus.io_wr_en) begin
      r_mem[bus.io_wr_addr] <= bus.io_wr_data;
    end
  end

  // Request capture and held response word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx       <= {ADDR_W{1'b0}};
      r_err       <= 1'b0;
      r_resp_data <= 32'h0000_0000;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx <= w_acc_idx;
        r_err <= w_acc_err;
      end
      if (w_load) begin
        r_resp_data <= w_rd_err ? NOP_WORD : w_rd_word;
        r_resp_err  <= w_rd_err;
      end
    end
  end

  assign bus.io_req_ready  = w_req_ready;
  assign bus.io_resp_valid = (r_state == ST_RESP);
  assign bus.io_resp_data  = r_resp_data;
  assign bus.io_resp_err   = r_resp_err;
  assign io_busy           = (r_state != ST_IDLE);

`ifdef IMEM_STATS_EN
  logic [15:0] r_stat_reqs;
  logic [15:0] r_stat_errs;

  // Saturating accept and error counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_reqs <= 16'h0000;
      r_stat_errs <= 16'h0000;
    end else begin
      if (w_accept && (r_stat_reqs != 16'hFFFF)) begin
        r_stat_reqs <= r_stat_reqs + 16'h0001;
      end
      if (w_accept && w_acc_err && (r_stat_errs != 16'hFFFF)) begin
        r_stat_errs <= r_stat_errs + 16'h0001;
      end
    end
  end

  assign io_stat_reqs = r_stat_reqs;
  assign io_stat_errs = r_stat_errs;
`else
  assign io_stat_reqs = 16'h0000;
  assign io_stat_errs = 16'h0000;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Randomized scoreboard bench for imem_responder at LATENCY 1, 2 and 3 side by side.
`timescale 1ns/1ps
module tb_imem_responder;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NRAND  = 1500;
  localparam int NDRAIN = 20;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int L = g + 1;

    logic        reset;
    logic        busy;
    logic [15:0] stat_reqs;
    logic [15:0] stat_errs;
    exp_t        q[$];
    exp_t        cur;
    bit          started = 1'b0;
    logic [31:0] mem [DEPTH];

    imem_responder_if #(.ADDR_W(ADDR_W)) bus ();

    imem_responder #(.ADDR_W(ADDR_W), .LATENCY(L)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus.slave),
      .io_busy     (busy),
      .io_stat_reqs(stat_reqs),
      .io_stat_errs(stat_errs)
    );

    // Monitor: pops one expectation per new response, then checks it is held.
    always @(negedge clock) begin
      if (reset) begin
        started = 1'b0;
      end else if (bus.io_resp_valid) begin
        if (!started) begin
          check($sformatf("L%0d resp_expected", L), 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            cur = q.pop_front();
            check($sformatf("L%0d resp_data", L), bus.io_resp_data, cur.data);
            check($sformatf("L%0d resp_err", L), 32'(bus.io_resp_err), 32'(cur.err));
            check($sformatf("L%0d resp_latency", L), 32'(cyc), 32'(cur.due));
          end
          started = 1'b1;
        end else begin
          check($sformatf("L%0d hold_data", L), bus.io_resp_data, cur.data);
          check($sformatf("L%0d hold_err", L), 32'(bus.io_resp_err), 32'(cur.err));
        end
        if (bus.io_resp_ready) started = 1'b0;
      end
    end

    // Driver plus transaction-level reference model.
    initial begin
      bit          outstanding;
      bit          pend_valid;
      bit          pend_err;
      bit          exp_valid;
      bit          exp_ready;
      bit          do_rst;
      bit          prev_rst;
      bit          rr;
      bit          rv;
      bit          we;
      bit          a_err;
      int          due;
      int          pend_edge;
      int          pend_idx;
      int          widx;
      int          i;
      int          sel;
      int          n_req;
      int          n_err;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;

      outstanding = 1'b0;
      pend_valid  = 1'b0;
      pend_idx    = 0;
      prev_rst    = 1'b0;
      n_req       = 0;
      n_err       = 0;
      due         = 0;
      pend_edge   = 0;
      reset             = 1'b1;
      bus.io_req_valid  = 1'b0;
      bus.io_req_addr   = 32'h0;
      bus.io_resp_ready = 1'b0;
      bus.io_wr_en      = 1'b0;
      bus.io_wr_addr    = '0;
      bus.io_wr_data    = 32'h0;
      repeat (2) @(posedge clock);
      #1;
      check($sformatf("L%0d rst_busy", L), 32'(busy), 32'd0);
      check($sformatf("L%0d rst_valid", L), 32'(bus.io_resp_valid), 32'd0);
      check($sformatf("L%0d rst_ready", L), 32'(bus.io_req_ready), 32'd1);
      check($sformatf("L%0d rst_data", L), bus.io_resp_data, 32'h0);
      check($sformatf("L%0d rst_err", L), 32'(bus.io_resp_err), 32'd0);
      check($sformatf("L%0d rst_stats", L), {stat_reqs, stat_errs}, 32'h0);

      // Load the whole program image through the write port.
      reset = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        wdata          = $urandom;
        bus.io_wr_en   = 1'b1;
        bus.io_wr_addr = ADDR_W'(k);
        bus.io_wr_data = wdata;
        mem[k]         = wdata;
        @(posedge clock);
        #1;
      end
      bus.io_wr_en = 1'b0;

      for (int it = 0; it < NRAND + NDRAIN; it++) begin
        i         = cyc;
        exp_valid = outstanding && (i >= due);
        if (it < NRAND) begin
          do_rst = ($urandom_range(0, 199) == 0);
          rr     = ($urandom_range(0, 99) < 70);
          rv     = ($urandom_range(0, 99) < 60);
          we     = !do_rst && ($urandom_range(0, 99) < 30);
        end else begin
          do_rst = 1'b0;
          rr     = 1'b1;
          rv     = 1'b0;
          we     = 1'b0;
        end
        sel = $urandom_range(0, 9);
        if (sel == 0)      addr = 32'($urandom_range(0, 4 * DEPTH - 1) | 1);
        else if (sel == 1) addr = 32'($urandom) | 32'h0000_0400;
        else               addr = 32'($urandom_range(0, DEPTH - 1) * 4);
        a_err = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
        case ($urandom_range(0, 2))
          0:       widx = $urandom_range(0, DEPTH - 1);
          1:       widx = int'((addr / 4) % DEPTH);
          default: widx = pend_idx;
        endcase
        wdata = $urandom;

        reset             = do_rst;
        bus.io_req_valid  = rv;
        bus.io_req_addr   = addr;
        bus.io_resp_ready = rr;
        bus.io_wr_en      = we;
        bus.io_wr_addr    = ADDR_W'(widx);
        bus.io_wr_data    = wdata;
        #1;

        exp_ready = !outstanding || (exp_valid && rr);
        check($sformatf("L%0d busy", L), 32'(busy), 32'(outstanding));
        check($sformatf("L%0d resp_valid", L), 32'(bus.io_resp_valid), 32'(exp_valid));
        check($sformatf("L%0d req_ready", L), 32'(bus.io_req_ready), 32'(exp_ready));
`ifdef IMEM_STATS_EN
        check($sformatf("L%0d stat_reqs", L), 32'(stat_reqs), 32'(n_req));
        check($sformatf("L%0d stat_errs", L), 32'(stat_errs), 32'(n_err));
`else
        check($sformatf("L%0d stat_off", L), {stat_reqs, stat_errs}, 32'h0);
`endif
        if (prev_rst) begin
          check($sformatf("L%0d post_rst_data", L), bus.io_resp_data, 32'h0);
          check($sformatf("L%0d post_rst_err", L), 32'(bus.io_resp_err), 32'd0);
        end

        // Effects of the coming edge.
        if (do_rst) begin
          outstanding = 1'b0;
          pend_valid  = 1'b0;
          n_req       = 0;
          n_err       = 0;
          q.delete();
        end else begin
          if (exp_valid && rr) outstanding = 1'b0;
          if (rv && exp_ready) begin
            outstanding = 1'b1;
            due         = i + L;
            pend_edge   = i + L;
            pend_idx    = int'((addr / 4) % DEPTH);
            pend_err    = a_err;
            pend_valid  = 1'b1;
            if (n_req < 65535) n_req++;
            if (a_err && n_err < 65535) n_err++;
          end
          if (we) mem[widx] = wdata;
          if (pend_valid && pend_edge == i + 1) begin
            exp_data = pend_err ? 32'h0000_0013 : mem[pend_idx];
            q.push_back('{exp_data, pend_err, pend_edge});
            pend_valid = 1'b0;
          end
        end
        prev_rst = do_rst;
        @(posedge clock);
        #1;
      end

      bus.io_resp_ready = 1'b0;
      @(negedge clock);
      #1;
      check($sformatf("L%0d drained_busy", L), 32'(busy), 32'd0);
      check($sformatf("L%0d queue_drained", L), 32'(q.size()), 32'd0);
      done_cnt++;
    end
  end

  initial begin
    wait (done_cnt == 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got done=%0d expected 3", done_cnt);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder for the processor's fetch initiator.
- Accepts one fetch request at a time (valid/ready), returns the 32-bit word after a fixed latency, and holds the response until the processor accepts it.
- Has a side write port so the bench or boot logic can load a program.
- Sits between the processor core and the program image, inside the processor top.

Parameters:
- ADDR_W, 8, word-address width; depth = 2^ADDR_W 32-bit words.
- LATENCY, 1, cycles from request acceptance to first io_resp_valid; legal range 1..8.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- io_req_valid  in  1  fetch request present.
- io_req_ready  out  1  responder can accept a request this cycle.
- io_req_addr  in  32  byte address of the fetch.
- io_resp_valid  out  1  response word available.
- io_resp_ready  in  1  processor accepts the response this cycle.
- io_resp_data  out  32  fetched instruction word.
- io_resp_err  out  1  fetch was misaligned or out of range.
- io_wr_en  in  1  program-load write strobe.
- io_wr_addr  in  ADDR_W  word address of the write.
- io_wr_data  in  32  word to write.
- io_busy  out  1  a request is outstanding (WAIT or RESP).
- io_stat_reqs  out  16  accepted-request count (see Optional Feature).
- io_stat_errs  out  16  error-response count (see Optional Feature).

Behaviour:
- Reset values: state=IDLE, io_resp_valid=0, io_resp_data=0, io_resp_err=0, io_busy=0, latency counter=0, stats=0.
- Reset discards any outstanding request. Memory contents are not cleared. Reset takes priority over every other event in the same cycle.
- States:
  - IDLE: io_req_ready=1.
  - WAIT: counting; io_req_ready=0.
  - RESP: io_resp_valid=1; io_req_ready=io_resp_ready.
- Accept: io_req_valid && io_req_ready on a rising edge. The address is captured at acceptance.
- Transitions on accept:
  - LATENCY=1: go directly to RESP; response visible the next cycle.
  - LATENCY>1: go to WAIT and load counter=LATENCY-1.
- WAIT decrements the counter each cycle. When the counter reaches 1, the next state is RESP.
- io_resp_valid therefore rises exactly LATENCY cycles after the accept edge.
- Word read: occurs on the transition into RESP, at index addr[ADDR_W+1:2]. A write to the same word in that same cycle is bypassed, so the new io_wr_data is returned.
- Error condition: addr[1:0]!=0 or addr[31:ADDR_W+2]!=0.
  - io_resp_err=1 and io_resp_data=0x00000013 (NOP); memory is not read.
- RESP holds io_resp_data and io_resp_err stable until io_resp_valid && io_resp_ready.
- On the RESP handshake:
  - If io_req_valid is also high, the new request is accepted in the same cycle (back-to-back). Next state follows the accept rules above; with LATENCY=1, io_resp_valid stays high with new data.
  - Otherwise, go to IDLE and drop io_resp_valid.
- Throughput: one fetch per LATENCY cycles with io_resp_ready held high.
- Writes:
  - Accepted in any state, including during WAIT/RESP.
  - A write after the word was latched into RESP does not alter the held response.
- io_busy = (state != IDLE).

Optional Feature:
- Macro: IMEM_STATS_EN.
- Defined:
  - io_stat_reqs increments on every accepted request.
  - io_stat_errs increments on every accepted request that will produce io_resp_err=1.
  - Both counters saturate at 0xFFFF and clear only on reset.
- Not defined: both ports are driven constant 0 and no counter flops are instantiated. Port list is identical either way.

Test Plan:
- Reset cleanup: assert reset while in WAIT (LATENCY=3, addr 0x10 accepted) -> next cycle io_busy=0, io_resp_valid=0, io_req_ready=1; the word written at 0x04 before reset is still readable afterwards.
- Basic fetch: load word 5=0xDEADBEEF via write port; LATENCY=1; request addr 0x14 -> io_resp_valid=1 one cycle later, data 0xDEADBEEF, err=0.
- Latency and hold: LATENCY=3; request addr 0x00 (word 0=0x00500093) with io_resp_ready=0 for 4 cycles -> valid rises 3 cycles after accept, data held stable, io_req_ready=0 throughout.
- Errors:
  - addr 0x06 -> err=1, data=0x00000013.
  - addr 0x400 with ADDR_W=8 -> err=1.
  - With IMEM_STATS_EN, io_stat_errs=2 and io_stat_reqs=2 after both.
- Back-to-back: LATENCY=1; addrs 0x00, 0x04, 0x08 with io_resp_ready=1 -> three consecutive valid cycles returning words 0, 1, 2 in order.
- Write bypass: LATENCY=2; request 0x0C; write word 3=0x12345678 in the cycle WAIT→RESP -> response 0x12345678. A later write of 0xAAAAAAAA during RESP leaves the held data 0x12345678.
